// File: rtl/mult_lut.sv
// mult_lut: self-initialising multiplication lookup table.
// After reset the block walks every {a,b} address and writes the product
// into an inferred RAM, then serves one lookup per cycle with a fixed
// two-edge result latency after the accepting edge.
// Optional build macro: MULT_LUT_SIGNED_EN (two's-complement operands/products).
module mult_lut #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               req_valid,
    output logic               req_ready,
    output logic               busy,
    output logic               res_valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int AW    = 2 * WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            accept;

    logic [AW-1:0]   mem [DEPTH];

    logic [AW-1:0]   addr_p0;
    logic            vld_p0;
    logic [AW-1:0]   rd_p1;
    logic            vld_p1;

    // Exact product of the a field (hi) and b field (lo) in 2*WIDTH bits.
    // The full product always fits, so truncation to AW bits loses nothing.
    function automatic logic [AW-1:0] lut_product(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo);
`ifdef MULT_LUT_SIGNED_EN
        logic signed [AW-1:0] sh;
        logic signed [AW-1:0] sl;
        logic signed [AW-1:0] sp;
        sh = signed'({{WIDTH{hi[WIDTH-1]}}, hi});
        sl = signed'({{WIDTH{lo[WIDTH-1]}}, lo});
        sp = sh * sl;
        return unsigned'(sp);
`else
        logic [AW-1:0] uh;
        logic [AW-1:0] ul;
        uh = {{WIDTH{1'b0}}, hi};
        ul = {{WIDTH{1'b0}}, lo};
        return uh * ul;
`endif
    endfunction

    assign accept = req_valid & req_ready;

    // Control FSM: fill counter walks the table in INIT, then hands over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state     <= RUN;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                RUN: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= INIT;
                    cnt       <= '0;
                    busy      <= 1'b1;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Table fill: one product written per INIT cycle at the counter address.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[cnt] <= lut_product(cnt[AW-1:WIDTH], cnt[WIDTH-1:0]);
    end

    // Stage p0: capture the lookup address {a, b}.
    always_ff @(posedge clk) begin
        addr_p0 <= {a, b};
    end

    // Stage p1: registered RAM read from the captured address.
    always_ff @(posedge clk) begin
        rd_p1 <= mem[addr_p0];
    end

    // Valid pipeline alongside the data; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            vld_p0    <= accept;
            vld_p1    <= vld_p0;
            res_valid <= vld_p1;
        end
    end

    // Stage p2: output register, holds the last product between pulses.
    always_ff @(posedge clk) begin
        if (rst)
            result <= '0;
        else if (vld_p1)
            result <= rd_p1;
    end

endmodule

// File: tb/tb_mult_lut.sv
// Directed bench for mult_lut (WIDTH=3): init timing, sweep, gapped traffic,
// resets during init and during run. Honours MULT_LUT_SIGNED_EN.
module tb_mult_lut;

    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           busy;
    logic           res_valid;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;

    mult_lut #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .busy      (busy),
        .res_valid (res_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference product of operand codes x and y, reduced to 2*W bits.
    function automatic logic [31:0] model(input int x, input int y);
        int sx;
        int sy;
        sx = x;
        sy = y;
`ifdef MULT_LUT_SIGNED_EN
        if (sx >= (1 << (W - 1))) sx = sx - (1 << W);
        if (sy >= (1 << (W - 1))) sy = sy - (1 << W);
`endif
        return 32'((sx * sy) & ((1 << (2 * W)) - 1));
    endfunction

    // 64 edges of fill: busy/ready low and no result until the last edge.
    task automatic wait_init(input string tag);
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k < 64) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_ready"}, req_ready, 0);
                chk({tag, "_resv"}, res_valid, 0);
            end else begin
                chk({tag, "_busy_done"}, busy, 0);
                chk({tag, "_ready_up"}, req_ready, 1);
            end
        end
    endtask

    // All 64 pairs back to back; each result appears two edges after accept.
    task automatic sweep(input string tag);
        for (int j = 0; j < 66; j++) begin
            if (j < 64) begin
                a = W'(j >> W);
                b = W'(j & ((1 << W) - 1));
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (j >= 2) begin
                chk({tag, "_resv"}, res_valid, 1);
                chk({tag, "_result"}, result, model((j - 2) >> W, (j - 2) & ((1 << W) - 1)));
            end else begin
                chk({tag, "_lead"}, res_valid, 0);
            end
        end
        tick();
        chk({tag, "_tail"}, res_valid, 0);
    endtask

    task automatic single(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [31:0] exp, input string tag);
        a = x;
        b = y;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_e0"}, res_valid, 0);
        tick();
        chk({tag, "_e1"}, res_valid, 0);
        tick();
        chk({tag, "_e2v"}, res_valid, 1);
        chk({tag, "_e2r"}, result, exp);
    endtask

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_resv", res_valid, 0);
        chk("rst_result", result, 0);

        // Init with requests presented throughout
        a = 3'd7;
        b = 3'd7;
        req_valid = 1'b1;
        rst = 1'b0;
        wait_init("init");
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("init_noqueue", res_valid, 0);
        end

        sweep("sweep1");

`ifdef MULT_LUT_SIGNED_EN
        single(3'b100, 3'b100, 32'd16, "s_m4m4");
        single(3'b111, 3'b011, 32'd61, "s_m1p3");
        single(3'b011, 3'b011, 32'd9, "s_p3p3");
        single(3'b100, 3'b011, 32'd52, "s_m4p3");
`else
        single(3'd7, 3'd7, 32'd49, "u_7x7");
        single(3'd5, 3'd3, 32'd15, "u_5x3");
        single(3'd0, 3'd6, 32'd0, "u_0x6");
        single(3'd7, 3'd1, 32'd7, "u_7x1");
`endif

        // Gapped traffic: 3*4, three idle cycles, 6*7
        a = 3'd3;
        b = 3'd4;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("gap_e0", res_valid, 0);
        tick();
        chk("gap_e1", res_valid, 0);
        tick();
        chk("gap_r1v", res_valid, 1);
        chk("gap_r1", result, model(3, 4));
        tick();
        chk("gap_idle_v", res_valid, 0);
        chk("gap_hold1", result, model(3, 4));
        a = 3'd6;
        b = 3'd7;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("gap_idle2_v", res_valid, 0);
        chk("gap_hold2", result, model(3, 4));
        tick();
        chk("gap_idle3_v", res_valid, 0);
        chk("gap_hold3", result, model(3, 4));
        tick();
        chk("gap_r2v", res_valid, 1);
        chk("gap_r2", result, model(6, 7));

        // Reset mid-init at fill counter 30
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        chk("mid_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_ready", req_ready, 0);
        rst = 1'b0;
        wait_init("mid");
        sweep("sweep2");

        // Reset in RUN with two requests in flight
        a = 3'd2;
        b = 3'd5;
        req_valid = 1'b1;
        tick();
        a = 3'd6;
        b = 3'd1;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("run_rst_resv0", res_valid, 0);
        chk("run_rst_result0", result, 0);
        chk("run_rst_busy", busy, 1);
        chk("run_rst_ready", req_ready, 0);
        tick();
        chk("run_rst_resv1", res_valid, 0);
        chk("run_rst_result1", result, 0);
        rst = 1'b0;
        wait_init("refill");
        single(3'd2, 3'd2, 32'd4, "refill_2x2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
